// File: rtl/a2_fetch_stage.sv
// rtl/a2_fetch_stage.sv - instruction fetch: PC, loadable instruction memory, IF/ID register
module a2_fetch_stage #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                imem_we,
    input  logic [PC_WIDTH-1:0] imem_waddr,
    input  logic [7:0]          imem_wdata,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                id_valid,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [7:0]          id_instr,
    output logic [1:0]          id_opcode,
    output logic [2:0]          id_rd,
    output logic [2:0]          id_imm,
    output logic                halted
);

    localparam int DEPTH = 1 << PC_WIDTH;
    localparam logic [7:0] HALT_WORD = 8'hFF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          fetch_word;
    logic                running;
    logic                redirect;
    logic                halt_fetch;

    // Combinational read sees the pre-write contents on a same-address write.
    assign fetch_word = mem[pc];
    assign redirect   = running && branch_taken;
    assign halt_fetch = running && !branch_taken && !stall && (fetch_word == HALT_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (halt_fetch) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state == S_RUN);
        halted  = (state == S_HALT);
    end

    // A taken branch beats a stall; the halt word parks the PC on itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (redirect) begin
            pc <= branch_target;
        end else if (stall || halt_fetch) begin
            pc <= pc;
        end else if (running) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || redirect) begin
            id_valid <= 1'b0;
            id_instr <= 8'h00;
            id_pc    <= '0;
        end else if (stall) begin
            id_valid <= id_valid;
        end else if (running) begin
            id_valid <= 1'b1;
            id_instr <= fetch_word;
            id_pc    <= pc;
        end else begin
            id_valid <= 1'b0;
            id_instr <= 8'h00;
            id_pc    <= '0;
        end
    end

    assign pc_out    = pc;
    assign id_opcode = id_instr[7:6];
    assign id_rd     = id_instr[5:3];
    assign id_imm    = id_instr[2:0];

endmodule

// File: doc/a2_fetch_stage.md
# a2_fetch_stage

Instruction-fetch stage with program counter, loadable instruction memory and IF/ID pipeline register for the 8-bit pipelined datapath. Sits directly upstream of `a2_sign_extender`: its registered `id_imm` output drives the extender's 3-bit `unextended` input. Field-decoded outputs also feed the register file and control unit of the decode stage.

## Interface
- `PC_WIDTH`, 4, program counter width; memory depth is 2**PC_WIDTH words of 8 bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  IDLE -> RUN request; ignored in RUN and HALT.
- `stall`  in  1  hazard stall: hold PC and IF/ID.
- `flush`  in  1  replace IF/ID contents with a bubble.
- `branch_taken`  in  1  redirect PC to `branch_target`.
- `branch_target`  in  PC_WIDTH  redirect address.
- `imem_we`  in  1  instruction memory write enable.
- `imem_waddr`  in  PC_WIDTH  write address.
- `imem_wdata`  in  8  write data.
- `pc_out`  out  PC_WIDTH  current fetch address.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_pc`  out  PC_WIDTH  address of the instruction in IF/ID.
- `id_instr`  out  8  raw instruction in IF/ID.
- `id_opcode`  out  2  `id_instr[7:6]`.
- `id_rd`  out  3  `id_instr[5:3]`.
- `id_imm`  out  3  `id_instr[2:0]` (rs or immediate; sign extender input).
- `halted`  out  1  high in HALT state.

## Operation
- FSM: IDLE, RUN, HALT.
  - IDLE -> RUN when `start`=1.
  - RUN -> HALT when the unstalled, unredirected fetch reads 8'hFF.
  - HALT exits only on `reset`.
- Memory: 2**PC_WIDTH x 8, synchronous write, combinational read at `pc_out`.
  - Writes are accepted in any state.
  - Same-cycle read of the address being written returns the old data.
  - Reset clears every word to 8'h00.
- PC update, first match wins:
  1. reset -> 0.
  2. RUN and `branch_taken` -> `branch_target`; this overrides `stall`.
  3. `stall` -> hold.
  4. Fetch of 8'hFF in RUN -> hold.
  5. RUN -> pc+1, wrapping from 2**PC_WIDTH-1 to 0.
  6. IDLE or HALT -> hold.
- IF/ID update, first match wins:
  1. reset -> valid=0, instr=0, id_pc=0.
  2. `flush` or (RUN and `branch_taken`) -> bubble (valid=0, instr=0, id_pc=0).
  3. `stall` -> hold all fields.
  4. RUN -> instr=mem[pc], id_pc=pc, valid=1.
  5. IDLE or HALT -> bubble.
- The halt word itself enters IF/ID with valid=1; every later cycle in HALT inserts a bubble.
- Decoded fields are pure slices of the registered `id_instr`, so they are zero in a bubble.
- `halted` = (state==HALT).

## Timing
- Reset values: `pc_out`=0, `id_valid`=0, `id_pc`=0, `id_instr`=0, `id_opcode`=0, `id_rd`=0, `id_imm`=0, `halted`=0, state=IDLE.
- First fetch: after the edge with `start`=1, state=RUN and `pc_out`=0.
  - mem[0] appears on `id_instr` after the next edge.
- Latency: one cycle from `pc_out`=p (RUN, no stall or redirect) to `id_pc`=p, `id_valid`=1.
- Branch: the edge with `branch_taken`=1 sets `pc_out`=target and bubbles IF/ID.
  - mem[target] appears one edge later.
- Stall held for N cycles: `pc_out` and all `id_*` are frozen for N edges, then fetch resumes at the same pc.
- `flush` and `stall` together: IF/ID becomes a bubble; PC holds.
- `start` coincident with `reset`: reset wins; state stays IDLE.
- Reset mid-RUN: on the next edge all outputs return to reset values and memory is cleared.

## Test plan
- Load mem[0..3]=8'h1A, 8'h2E, 8'h07, 8'hFF, then pulse `start`.
  - Required: `id_instr` sequence 1A, 2E, 07, FF on consecutive cycles with `id_pc` 0..3.
  - For 8'h2E: `id_opcode`=0, `id_rd`=5, `id_imm`=6.
  - After FF: `halted`=1, `pc_out` stuck at 3, `id_valid`=0.
- Running at pc=1, assert `stall` for 3 cycles.
  - Required: `pc_out`=1 and `id_instr`=mem[0] held for 3 cycles, then mem[1] appears.
- `branch_taken`=1 with target=9 while pc=2.
  - Required: next cycle `pc_out`=9 and `id_valid`=0.
  - Following cycle: `id_pc`=9, `id_instr`=mem[9].
- Fill memory with 8'h01 and run 17 cycles.
  - Required: `pc_out` wraps from 15 to 0; `id_pc` follows 15 then 0 with `id_valid`=1 throughout.
- Assert `flush` and `stall` together at pc=4.
  - Required: bubble in IF/ID, `pc_out` stays 4.
- Assert `reset` mid-run.
  - Required: all outputs zero, state IDLE, mem[0] reads 8'h00.
